// File: rtl/bcd_counter.sv
// bcd_counter: two-digit BCD modulo counter driven by a divider strobe, with
// run/pause/clear control and a one-cycle terminal-count pulse on wrap.
// Optional feature macro: BCD_CNT_DOWN_EN adds the dir port and down counting.
`timescale 1ns/1ps
module bcd_counter #(
    parameter int unsigned MAX_TENS = 5,
    parameter int unsigned MAX_ONES = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cnt_en,
    input  logic       start,
    input  logic       stop,
    input  logic       clr,
`ifdef BCD_CNT_DOWN_EN
    input  logic       dir,
`endif
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       running,
    output logic       tc
);

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] MAX_T = DIGIT_W'(MAX_TENS);
    localparam logic [DIGIT_W-1:0] MAX_O = DIGIT_W'(MAX_ONES);
    localparam logic [DIGIT_W-1:0] NINE  = DIGIT_W'(9);
    localparam logic [DIGIT_W-1:0] ZERO  = DIGIT_W'(0);
    localparam logic [DIGIT_W-1:0] ONE   = DIGIT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DIGIT_W-1:0] ones_nxt;
    logic [DIGIT_W-1:0] tens_nxt;
    logic               tc_nxt;
    logic               running_nxt;
    logic               do_cnt;

    // State, digit and flag registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            ones    <= ZERO;
            tens    <= ZERO;
            tc      <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= state_nxt;
            ones    <= ones_nxt;
            tens    <= tens_nxt;
            tc      <= tc_nxt;
            running <= running_nxt;
        end
    end

    // Next state and digit-wise BCD update; counting is gated by the current state only.
    always_comb begin
        state_nxt   = state;
        ones_nxt    = ones;
        tens_nxt    = tens;
        tc_nxt      = 1'b0;
        do_cnt      = (state == ST_RUN) && cnt_en && !clr;

        case (state)
            ST_IDLE:  if (start && !stop) state_nxt = ST_RUN;
            ST_RUN:   if (stop)           state_nxt = ST_PAUSE;
            ST_PAUSE: if (start && !stop) state_nxt = ST_RUN;
            default:                      state_nxt = ST_IDLE;
        endcase

        if (do_cnt) begin
`ifdef BCD_CNT_DOWN_EN
            if (dir) begin
                if ((tens == ZERO) && (ones == ZERO)) begin
                    tens_nxt = MAX_T;
                    ones_nxt = MAX_O;
                    tc_nxt   = 1'b1;
                end else if (ones == ZERO) begin
                    ones_nxt = NINE;
                    tens_nxt = tens - ONE;
                end else begin
                    ones_nxt = ones - ONE;
                end
            end else
`endif
            begin
                if ((tens == MAX_T) && (ones == MAX_O)) begin
                    tens_nxt = ZERO;
                    ones_nxt = ZERO;
                    tc_nxt   = 1'b1;
                end else if (ones == NINE) begin
                    ones_nxt = ZERO;
                    tens_nxt = tens + ONE;
                end else begin
                    ones_nxt = ones + ONE;
                end
            end
        end

        // Clear overrides everything, including a simultaneous wrap.
        if (clr) begin
            state_nxt = ST_IDLE;
            ones_nxt  = ZERO;
            tens_nxt  = ZERO;
            tc_nxt    = 1'b0;
        end

        running_nxt = (state_nxt == ST_RUN);
    end

endmodule
